// File: rtl/mem_access_ctrl.sv
// Sequences one 32-bit load/store as two 16-bit phases on an asynchronous SRAM.
// Holds ready low until the access retires, so the pipeline freezes meanwhile.
module mem_access_ctrl #(
    parameter logic [31:0] BASE_ADDR    = 32'd1024,
    parameter int unsigned PHASE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic [31:0] rdata,
    output logic [17:0] SRAM_ADDR,
    output logic [15:0] SRAM_DQ_OUT,
    input  logic [15:0] SRAM_DQ_IN,
    output logic        SRAM_DQ_OE,
    output logic        SRAM_WE_N
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(PHASE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [16:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0] offset;
    logic        req;
    logic        phase_hi;
    logic        unused_offset_bits;

    // Window-relative byte offset; wraps modulo 2^32, and the half-word index wraps modulo 2^18.
    assign offset             = address - BASE_ADDR;
    assign unused_offset_bits = ^{offset[31:19], offset[1:0]};
    assign req                = MEM_R_EN | MEM_W_EN;
    assign phase_hi           = (state_q == S_HIGH);
    assign rdata              = rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        ready       = 1'b0;
        SRAM_ADDR   = '0;
        SRAM_DQ_OUT = '0;
        SRAM_DQ_OE  = 1'b0;
        SRAM_WE_N   = 1'b1;

        case (state_q)
            S_IDLE: begin
                ready = ~req;
                if (req) begin
                    // A store wins over a simultaneous load request.
                    wr_d    = MEM_W_EN;
                    addr_d  = offset[18:2];
                    wdata_d = wdata;
                    cnt_d   = '0;
                    state_d = S_LOW;
                end
            end
            S_LOW, S_HIGH: begin
                SRAM_ADDR = {addr_q, phase_hi};
                if (wr_q) begin
                    SRAM_DQ_OUT = phase_hi ? wdata_q[31:16] : wdata_q[15:0];
                    SRAM_DQ_OE  = 1'b1;
                    SRAM_WE_N   = 1'b0;
                end
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (!wr_q) begin
                        if (phase_hi) rdata_d[31:16] = SRAM_DQ_IN;
                        else          rdata_d[15:0]  = SRAM_DQ_IN;
                    end
                    state_d = phase_hi ? S_DONE : S_HIGH;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                // Request inputs still hold the retiring instruction, so they are ignored here.
                ready   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: SRAM model plus a word-level reference memory.
module tb_mem_access_ctrl;

    localparam int          P    = 2;
    localparam logic [31:0] BASE = 32'd1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_R_EN, MEM_W_EN;
    logic [31:0] address, wdata;
    logic        ready;
    logic [31:0] rdata;
    logic [17:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_OUT, SRAM_DQ_IN;
    logic        SRAM_DQ_OE, SRAM_WE_N;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bit [15:0]   sram [0:262143];
    logic        pl_en = 1'b0;
    logic [17:0] pl_addr = '0;
    logic [15:0] pl_data = '0;

    logic [31:0] ref_mem [int unsigned];
    logic [31:0] exp_rdata = '0;

    mem_access_ctrl #(.BASE_ADDR(BASE), .PHASE_CYCLES(P)) dut (
        .clk        (clk),
        .rst        (rst),
        .MEM_R_EN   (MEM_R_EN),
        .MEM_W_EN   (MEM_W_EN),
        .address    (address),
        .wdata      (wdata),
        .ready      (ready),
        .rdata      (rdata),
        .SRAM_ADDR  (SRAM_ADDR),
        .SRAM_DQ_OUT(SRAM_DQ_OUT),
        .SRAM_DQ_IN (SRAM_DQ_IN),
        .SRAM_DQ_OE (SRAM_DQ_OE),
        .SRAM_WE_N  (SRAM_WE_N)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Asynchronous SRAM: combinational read, write committed while the strobe is low.
    assign SRAM_DQ_IN = sram[SRAM_ADDR];
    always @(posedge clk) begin
        if (!SRAM_WE_N)  sram[SRAM_ADDR] <= SRAM_DQ_OUT;
        else if (pl_en)  sram[pl_addr]   <= pl_data;
    end

    function automatic logic [16:0] word_index(input logic [31:0] a);
        return 17'((a - BASE) >> 2);
    endfunction

    function automatic logic [31:0] ref_read(input logic [16:0] wi);
        if (ref_mem.exists(int'(wi))) return ref_mem[int'(wi)];
        return 32'd0;
    endfunction

    // Issues one request at posedge+1 of cycle 0 and checks every cycle through the ready cycle.
    task automatic run_access(input logic r, input logic w, input logic [31:0] a,
                              input logic [31:0] d, output int done_cyc);
        logic [16:0] wi;
        logic [31:0] exp_rd;
        logic        hi;
        logic [15:0] exp_dq;
        wi       = word_index(a);
        exp_rd   = w ? exp_rdata : ref_read(wi);
        MEM_R_EN = r;
        MEM_W_EN = w;
        address  = a;
        wdata    = d;
        done_cyc = -1;
        for (int c = 0; c <= 2*P+1; c++) begin
            @(negedge clk);
            if (c <= 2*P) begin
                n_checks++;
                if (ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_ready cycle %0d: got %b expected 0", c, ready);
                end
            end else begin
                n_checks++;
                if (ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL done_ready: got %b expected 1", ready);
                end else begin
                    done_cyc = cyc;
                end
                n_checks++;
                if (rdata !== exp_rd) begin
                    n_fail++;
                    $display("FAIL rdata addr=%h: got %h expected %h", a, rdata, exp_rd);
                end
            end
            if (c >= 1 && c <= 2*P) begin
                hi = (c > P);
                n_checks++;
                if (SRAM_ADDR !== {wi, hi}) begin
                    n_fail++;
                    $display("FAIL sram_addr cycle %0d: got %h expected %h", c, SRAM_ADDR, {wi, hi});
                end
                n_checks++;
                if ({SRAM_DQ_OE, SRAM_WE_N} !== (w ? 2'b10 : 2'b01)) begin
                    n_fail++;
                    $display("FAIL oe_we cycle %0d: got %b expected %b", c, {SRAM_DQ_OE, SRAM_WE_N}, (w ? 2'b10 : 2'b01));
                end
                if (w) begin
                    exp_dq = hi ? d[31:16] : d[15:0];
                    n_checks++;
                    if (SRAM_DQ_OUT !== exp_dq) begin
                        n_fail++;
                        $display("FAIL dq_out cycle %0d: got %h expected %h", c, SRAM_DQ_OUT, exp_dq);
                    end
                end
            end else begin
                n_checks++;
                if ({SRAM_ADDR, SRAM_DQ_OE, SRAM_WE_N} !== {18'd0, 2'b01}) begin
                    n_fail++;
                    $display("FAIL bus_idle cycle %0d: got %h/%b%b expected 0/01", c, SRAM_ADDR, SRAM_DQ_OE, SRAM_WE_N);
                end
            end
            @(posedge clk); #1;
        end
        if (w) ref_mem[int'(wi)] = d;
        exp_rdata = exp_rd;
        $display("access r=%b w=%b addr=%h wdata=%h rdata=%h done_cycle=%0d", r, w, a, d, rdata, done_cyc);
    endtask

    task automatic set_idle();
        MEM_R_EN = 1'b0;
        MEM_W_EN = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        n_checks++;
        if ({ready, rdata, SRAM_WE_N, SRAM_DQ_OE, SRAM_ADDR, SRAM_DQ_OUT} !== {1'b1, 32'd0, 1'b1, 1'b0, 18'd0, 16'd0}) begin
            n_fail++;
            $display("FAIL %s: got ready=%b rdata=%h we_n=%b oe=%b addr=%h dq=%h expected 1/0/1/0/0/0",
                     tag, ready, rdata, SRAM_WE_N, SRAM_DQ_OE, SRAM_ADDR, SRAM_DQ_OUT);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; set_idle(); address = '0; wdata = '0;
        #3;
        check_reset_outputs("reset_initial");
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_ready: got %b expected 1", ready);
        end
        #2 rst = 1'b1;
        #1 check_reset_outputs("reset_async");
        #1 rst = 1'b0;
        @(posedge clk); #1;
        $display("reset checks done");
    endtask

    task automatic test_store();
        int d;
        run_access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, d);
        set_idle();
        @(negedge clk);
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL store_post_idle_ready: got %b expected 1", ready);
        end
        n_checks++;
        if ({sram[3], sram[2]} !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL store_sram_content: got %h expected deadbeef", {sram[3], sram[2]});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_load();
        int d;
        pl_en = 1'b1; pl_addr = 18'd20; pl_data = 16'h5678;
        @(posedge clk); #1;
        pl_addr = 18'd21; pl_data = 16'h1234;
        @(posedge clk); #1;
        pl_en = 1'b0;
        ref_mem[10] = 32'h12345678;
        run_access(1'b1, 1'b0, 32'd1028, 32'h0, d);
        run_access(1'b1, 1'b0, BASE + 32'd40, 32'h0, d);
        set_idle();
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int d1, d2;
        run_access(1'b1, 1'b0, 32'd1028, 32'h0, d1);
        run_access(1'b1, 1'b0, BASE + 32'd41, 32'h0, d2);
        set_idle();
        n_checks++;
        if (d2 - d1 !== 6) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d expected 6", d2 - d1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_read_write_both();
        int d;
        run_access(1'b1, 1'b1, BASE + 32'd80, 32'h12345678, d);
        set_idle();
        @(posedge clk); #1;
        run_access(1'b1, 1'b0, BASE + 32'd80, 32'h0, d);
        set_idle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_access();
        int d;
        logic [16:0] wi;
        logic [31:0] old;
        wi = word_index(BASE + 32'd200);
        old = ref_read(wi);
        MEM_W_EN = 1'b1; MEM_R_EN = 1'b0; address = BASE + 32'd200; wdata = 32'hCAFEF00D;
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if ({SRAM_WE_N, SRAM_ADDR} !== {1'b0, wi, 1'b1}) begin
            n_fail++;
            $display("FAIL mid_high_phase: got we_n=%b addr=%h expected 0/%h", SRAM_WE_N, SRAM_ADDR, {wi, 1'b1});
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({SRAM_WE_N, SRAM_DQ_OE, SRAM_ADDR, SRAM_DQ_OUT} !== {1'b1, 1'b0, 18'd0, 16'd0}) begin
            n_fail++;
            $display("FAIL mid_reset_bus: got we_n=%b oe=%b addr=%h dq=%h expected 1/0/0/0",
                     SRAM_WE_N, SRAM_DQ_OE, SRAM_ADDR, SRAM_DQ_OUT);
        end
        set_idle();
        #1;
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_ready: got %b expected 1", ready);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        exp_rdata = 32'd0;
        ref_mem[int'(wi)] = {old[31:16], 16'hF00D};
        run_access(1'b1, 1'b0, BASE + 32'd200, 32'h0, d);
        set_idle();
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int d, gap;
        logic r, w;
        logic [31:0] a;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: begin r = 1'b1; w = 1'b0; end
                3, 4:    begin r = 1'b0; w = 1'b1; end
                default: begin r = 1'b1; w = 1'b1; end
            endcase
            if ($urandom_range(0, 9) < 7) a = BASE + 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
            else                          a = $urandom;
            run_access(r, w, a, $urandom, d);
            set_idle();
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                n_checks++;
                if (ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL random_gap_ready: got %b expected 1", ready);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_back_to_back();
        test_read_write_both();
        test_reset_mid_access();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
